iter_shifter: RTL
=================

Name: iter_shifter

Overview:
- Parametrised, multi-cycle ARM-style barrel shifter for the execute stage: LSL, LSR, ASR, ROR and RRX with full ARM register-shift carry-out semantics.
- Generalised in width and bits-per-cycle.
- Handshaked on both sides (valid/ready), so a slower, area-cheap shifter can sit between the register file read and the ALU operand-2 mux.

Parameters:
- WIDTH, 32, datapath width in bits (>=8, power of 2).
- STEP, 8, max bits shifted per cycle (power of 2, 1..WIDTH).
- AMT_W, 8, width of shift-amount input (ARM Rs[7:0]).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, others = pass-through.
- amount  in  AMT_W  unsigned shift amount (ignored for RRX).
- data_in  in  WIDTH  operand (Rm).
- carry_in  in  1  current CPSR C.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- data_out  out  WIDTH  shifted result.
- carry_out  out  1  shifter carry-out.

Behaviour:
- Reset: asynchronous, active-high, clears everything.
  - State returns to IDLE.
  - in_ready=1; out_valid=0; data_out=0; carry_out=0.
  - Reset mid-operation abandons the request; nothing is emitted.
- States:
  - IDLE: in_ready=1. in_valid&in_ready accepts the request (the accept edge).
  - BUSY: in_ready=0. Shifts one chunk per cycle.
  - DONE: out_valid=1. Moves to IDLE on out_ready.
- No new request is accepted in BUSY or DONE (in_ready=0); in_valid is ignored there.
- Effective amount eff, computed at the accept edge:
  - LSL/LSR: min(amount, WIDTH+1).
  - ASR: min(amount, WIDTH).
  - ROR: amount mod WIDTH.
  - RRX: 1.
  - Pass-through: 0.
- eff==0 at accept:
  - Go directly to DONE.
  - data_out=data_in.
  - carry_out=carry_in, except ROR with amount!=0 and amount mod WIDTH==0, where carry_out=data_in[WIDTH-1].
- eff>0:
  - Go to BUSY with remaining=eff.
  - Each cycle shift by k=min(remaining, STEP) and decrement remaining by k.
  - carry tracks the last bit shifted out (LSL: bit WIDTH-k; LSR/ASR/ROR: bit k-1).
  - LSL/LSR fill with 0; ASR fills with the sign bit; ROR wraps.
  - RRX: single step; result {carry_in, data[WIDTH-1:1]}, carry = data[0].
  - Go to DONE in the cycle remaining reaches 0.
- Saturating eff reproduces ARM rules without special cases:
  - LSL/LSR by WIDTH → result 0, C = last bit out.
  - LSL/LSR by more than WIDTH → result 0, C=0.
  - ASR by WIDTH or more → all sign bits, C=sign.
- Latency, from accept edge to out_valid high:
  - 1 cycle if eff==0.
  - otherwise ceil(eff/STEP)+1 cycles.
  - Worst case for WIDTH=32, STEP=8: LSL/LSR 33 → 6 cycles.
- data_out and carry_out:
  - Registered; stable while out_valid=1 and out_ready=0.
  - Hold their last value after the handshake.
- Throughput: one request per (latency+1) cycles minimum; no overlap.

Optional Feature:
- Macro: ITER_SHIFTER_NZ_FLAGS_EN.
- Defined:
  - Adds outputs n_flag (1) = data_out[WIDTH-1] and z_flag (1) = (data_out==0).
  - Both are registered and updated in the same cycle data_out is written.
  - Both reset to 0.
  - Used for MOVS/MVNS flag updates without the ALU.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
All cases use WIDTH=32, STEP=8 unless stated.
- LSL, data 0x80000001, amount 1, cin 0 → data_out 0x00000002, carry 1; out_valid 2 cycles after accept.
- LSR, data 0x80000000:
  - amount 32 → 0x00000000, carry 1; latency 5.
  - amount 33 → 0x00000000, carry 0; latency 6.
  - amount 200 → 0, carry 0.
- ASR, data 0x80000000:
  - amount 40 → 0xFFFFFFFF, carry 1.
  - amount 0, cin 0 → 0x80000000, carry 0; latency 1.
- ROR, data 0x000000F1:
  - amount 4 → 0x1000000F, carry 0.
  - amount 36 → same.
  - data 0x80000000, amount 32 → 0x80000000, carry 1; latency 1.
- RRX, data 0x00000003, cin 1 → 0x80000001, carry 1, latency 2. With the macro on: n_flag 1, z_flag 0. LSL 0x1 by 33 → z_flag 1.
- Handshake and reset:
  - Hold out_ready=0 for 3 cycles in DONE → data_out/out_valid stable; in_valid pulses ignored.
  - Assert reset during BUSY → out_valid 0, in_ready 1 immediately; the next request completes normally.
  - STEP=1 build: LSL amount 5 → latency 6.

Source files
------------

// File: rtl/iter_shifter.sv
// Multi-cycle ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX) with valid/ready on both sides.
// Define ITER_SHIFTER_NZ_FLAGS_EN to add registered n_flag/z_flag outputs.
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
`ifdef ITER_SHIFTER_NZ_FLAGS_EN
    ,
    output logic             n_flag,
    output logic             z_flag
`endif
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int XW = ((AMT_W > CW) ? AMT_W : CW) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [2:0] {
        OP_LSL = 3'd0, OP_LSR = 3'd1, OP_ASR = 3'd2, OP_ROR = 3'd3, OP_RRX = 3'd4
    } op_e;

    state_e           state, state_next;
    logic [WIDTH-1:0] work;
    logic             carry_r;
    logic [CW-1:0]    rem;
    logic [2:0]       op_r;

    logic [XW-1:0]    amt_x, eff_x;
    logic [CW-1:0]    eff, k, km1, rem_next;
    logic [WIDTH-1:0] step_data, shifted_m1;
    logic             step_carry;
    logic             load_out, cout_d;
    logic [WIDTH-1:0] out_d;

    // Saturated amounts let the plain chunked loop produce the ARM edge cases.
    always_comb begin
        amt_x = XW'(amount);
        eff_x = '0;
        case (op)
            OP_LSL, OP_LSR: eff_x = (amt_x > XW'(WIDTH + 1)) ? XW'(WIDTH + 1) : amt_x;
            OP_ASR:         eff_x = (amt_x > XW'(WIDTH)) ? XW'(WIDTH) : amt_x;
            OP_ROR:         eff_x = amt_x & XW'(WIDTH - 1);
            OP_RRX:         eff_x = XW'(1);
            default:        eff_x = '0;
        endcase
        eff = CW'(eff_x);
    end

    always_comb begin
        k          = (rem > CW'(STEP)) ? CW'(STEP) : rem;
        km1        = k - CW'(1);
        rem_next   = rem - k;
        step_data  = work;
        step_carry = carry_r;
        shifted_m1 = work >> km1;
        case (op_r)
            OP_LSL: begin
                step_data  = work << k;
                shifted_m1 = work << km1;
                step_carry = shifted_m1[WIDTH-1];
            end
            OP_LSR: begin
                step_data  = work >> k;
                step_carry = shifted_m1[0];
            end
            OP_ASR: begin
                step_data  = $signed(work) >>> k;
                step_carry = shifted_m1[0];
            end
            OP_ROR: begin
                step_data  = (work >> k) | (work << (CW'(WIDTH) - k));
                step_carry = shifted_m1[0];
            end
            OP_RRX: begin
                step_data  = {carry_r, work[WIDTH-1:1]};
                step_carry = work[0];
            end
            default: begin
                step_data  = work;
                step_carry = carry_r;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load_out   = 1'b0;
        out_d      = step_data;
        cout_d     = step_carry;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (eff == '0) begin
                        state_next = DONE;
                        load_out   = 1'b1;
                        out_d      = data_in;
                        // ROR by a nonzero multiple of WIDTH yields C = msb.
                        cout_d     = (op == OP_ROR && amount != '0) ? data_in[WIDTH-1] : carry_in;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (rem_next == '0) begin
                    state_next = DONE;
                    load_out   = 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work      <= '0;
            carry_r   <= 1'b0;
            rem       <= '0;
            op_r      <= '0;
            data_out  <= '0;
            carry_out <= 1'b0;
`ifdef ITER_SHIFTER_NZ_FLAGS_EN
            n_flag    <= 1'b0;
            z_flag    <= 1'b0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
                work    <= data_in;
                carry_r <= carry_in;
                rem     <= eff;
                op_r    <= op;
            end else if (state == BUSY) begin
                work    <= step_data;
                carry_r <= step_carry;
                rem     <= rem_next;
            end
            if (load_out) begin
                data_out  <= out_d;
                carry_out <= cout_d;
`ifdef ITER_SHIFTER_NZ_FLAGS_EN
                n_flag    <= out_d[WIDTH-1];
                z_flag    <= (out_d == '0);
`endif
            end
        end
    end

endmodule
